// File: rtl/vend_ctrl_fsm.sv
// Vending transaction controller: accumulates coin credit, arbitrates select/cancel,
// and emits registered one-cycle vend/error/refund pulses plus BCD credit for the display.
module vend_ctrl_fsm #(
  parameter int unsigned PRICE_A         = 75,
  parameter int unsigned PRICE_B         = 50,
  parameter int unsigned PRICE_C         = 35,
  parameter int unsigned PRICE_D         = 90,
  parameter int unsigned MAX_CREDIT      = 99,
  parameter int unsigned DISPENSE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       nickel,
  input  logic       dime,
  input  logic       quarter,
  input  logic       selA,
  input  logic       selB,
  input  logic       selC,
  input  logic       selD,
  input  logic       cancel,
  output logic       apple,
  output logic       banana,
  output logic       carrot,
  output logic       date,
  output logic       error,
  output logic [7:0] credit,
  output logic       change_valid,
  output logic [7:0] change,
  output logic       busy
);

  localparam int unsigned CRED_W = 7;
  localparam int unsigned SUM_W  = CRED_W + 1;
  localparam int unsigned CNT_W  = $clog2(DISPENSE_CYCLES + 1);

  typedef enum logic {
    READY    = 1'b0,
    DISPENSE = 1'b1
  } state_t;

  state_t              r_state;
  logic [CRED_W-1:0]   r_credit;
  logic [CNT_W-1:0]    r_cnt;
  logic [3:0]          r_item;
  logic                r_error;
  logic                r_change_valid;
  logic [7:0]          r_change;
  logic                r_busy;

  state_t              w_state_nxt;
  logic [CRED_W-1:0]   w_credit_nxt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic [3:0]          w_item_nxt;
  logic                w_error_nxt;
  logic                w_change_valid_nxt;
  logic [7:0]          w_change_nxt;
  logic                w_busy_nxt;

  logic [3:0]          w_sel;
  logic [2:0]          w_coin;
  logic                w_multi_sel;
  logic                w_multi_coin;
  logic [CRED_W-1:0]   w_price;
  logic [CRED_W-1:0]   w_coin_val;
  logic [SUM_W-1:0]    w_sum;

  // Binary 0..99 to two BCD digits.
  function automatic logic [7:0] bin2bcd(input logic [CRED_W-1:0] b);
    logic [3:0] tens;
    logic [3:0] units;
    tens  = 4'(b / CRED_W'(10));
    units = 4'(b % CRED_W'(10));
    return {tens, units};
  endfunction

  assign w_sel        = {selA, selB, selC, selD};
  assign w_coin       = {nickel, dime, quarter};
  assign w_multi_sel  = (w_sel & (w_sel - 4'd1)) != 4'd0;
  assign w_multi_coin = (w_coin & (w_coin - 3'd1)) != 3'd0;
  assign w_sum        = SUM_W'(r_credit) + SUM_W'(w_coin_val);

  always_comb begin
    w_price = '0;
    case (w_sel)
      4'b1000: w_price = CRED_W'(PRICE_A);
      4'b0100: w_price = CRED_W'(PRICE_B);
      4'b0010: w_price = CRED_W'(PRICE_C);
      4'b0001: w_price = CRED_W'(PRICE_D);
      default: w_price = '0;
    endcase
  end

  always_comb begin
    w_coin_val = '0;
    if (nickel)       w_coin_val = CRED_W'(5);
    else if (dime)    w_coin_val = CRED_W'(10);
    else if (quarter) w_coin_val = CRED_W'(25);
  end

  // Next-state and registered-output decode; READY priority is cancel > select > coin.
  always_comb begin
    w_state_nxt        = r_state;
    w_credit_nxt       = r_credit;
    w_cnt_nxt          = r_cnt;
    w_item_nxt         = 4'b0000;
    w_error_nxt        = 1'b0;
    w_change_valid_nxt = 1'b0;
    w_change_nxt       = r_change;
    w_busy_nxt         = 1'b0;

    case (r_state)
      READY: begin
        if (cancel) begin
          if (r_credit != '0) begin
            w_change_nxt       = bin2bcd(r_credit);
            w_change_valid_nxt = 1'b1;
            w_credit_nxt       = '0;
          end
        end else if (w_sel != 4'b0000) begin
          if (w_multi_sel || (r_credit < w_price)) begin
            w_error_nxt = 1'b1;
          end else begin
            w_item_nxt   = w_sel;
            w_credit_nxt = r_credit - w_price;
            w_state_nxt  = DISPENSE;
            w_cnt_nxt    = CNT_W'(DISPENSE_CYCLES);
            w_busy_nxt   = 1'b1;
          end
        end else if (w_coin != 3'b000) begin
          if (w_multi_coin || (w_sum > SUM_W'(MAX_CREDIT))) begin
            w_error_nxt = 1'b1;
          end else begin
            w_credit_nxt = CRED_W'(w_sum);
          end
        end
      end
      DISPENSE: begin
        // The cycle that holds count 1 is the last busy cycle.
        if (r_cnt <= CNT_W'(1)) begin
          w_state_nxt = READY;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt  = r_cnt - CNT_W'(1);
          w_busy_nxt = 1'b1;
        end
      end
      default: w_state_nxt = READY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= READY;
      r_credit       <= '0;
      r_cnt          <= '0;
      r_item         <= 4'b0000;
      r_error        <= 1'b0;
      r_change_valid <= 1'b0;
      r_change       <= 8'h00;
      r_busy         <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_credit       <= w_credit_nxt;
      r_cnt          <= w_cnt_nxt;
      r_item         <= w_item_nxt;
      r_error        <= w_error_nxt;
      r_change_valid <= w_change_valid_nxt;
      r_change       <= w_change_nxt;
      r_busy         <= w_busy_nxt;
    end
  end

  assign apple        = r_item[3];
  assign banana       = r_item[2];
  assign carrot       = r_item[1];
  assign date         = r_item[0];
  assign error        = r_error;
  assign change_valid = r_change_valid;
  assign change       = r_change;
  assign busy         = r_busy;
  assign credit       = bin2bcd(r_credit);

endmodule

// File: doc/vend_ctrl_fsm.md
Name: vend_ctrl_fsm

Overview:
Vending-machine transaction controller that sits directly upstream of the seven-segment display manager. It accepts coin and item-select inputs, holds the credit total, and decides vend or error. It drives the one-cycle item pulses (apple/banana/carrot/date/error) and the 2-digit BCD credit value that the display manager consumes, plus a change/refund output.

Parameters:
PRICE_A  75  apple price in cents (binary, multiple of 5, <= MAX_CREDIT)
PRICE_B  50  banana price in cents
PRICE_C  35  carrot price in cents
PRICE_D  90  date price in cents
MAX_CREDIT  99  highest credit held; must be <= 99 for 2-digit BCD
DISPENSE_CYCLES  4  length of the post-vend busy lockout, >= 1

Ports:
clk  in  1  system clock, all logic on posedge
reset  in  1  synchronous, active-high reset
nickel  in  1  coin-accepted strobe, 5 cents
dime  in  1  coin-accepted strobe, 10 cents
quarter  in  1  coin-accepted strobe, 25 cents
selA, selB, selC, selD  in  1 each  item select strobes
cancel  in  1  refund request
apple, banana, carrot, date  out  1 each  one-cycle vend pulse to display manager
error  out  1  one-cycle rejection pulse to display manager
credit  out  8  BCD credit: [7:4] tens, [3:0] units
change_valid  out  1  one-cycle refund strobe
change  out  8  BCD refund amount, meaningful when change_valid=1
busy  out  1  high during dispense lockout

Behaviour:
- Reset (sampled at posedge, reset=1): credit_bin=0, state=READY, lockout counter=0. apple/banana/carrot/date/error/change_valid/busy=0, change=8'h00. Reset overrides every other input in the same cycle, including mid-DISPENSE.
- Internal credit is held in binary, 0..MAX_CREDIT. credit is its BCD conversion. Conversion may be combinational from the register, with no added latency. Credit must never be a non-BCD nibble.
- All pulse outputs are registered. They assert the cycle after the triggering input is sampled (latency 1) and stay high exactly 1 cycle. Inputs are level-sampled every cycle. Upstream guarantees 1-cycle strobes, so the block does no edge detection.
- States: READY, DISPENSE.
- In READY, each cycle is evaluated in priority order cancel > select > coin. Inputs of lower priority in the same cycle are dropped silently, with no error.
  - cancel, credit>0: change=BCD(credit), change_valid=1, credit=0.
  - cancel, credit=0: no action.
  - Exactly one sel: if credit >= price, pulse the matching item output, credit -= price, go to DISPENSE, lockout counter = DISPENSE_CYCLES. If credit < price, error=1 and credit unchanged.
  - More than one sel asserted: error=1, no vend, credit unchanged.
  - Exactly one coin: if credit+value <= MAX_CREDIT, add it. Otherwise error=1 and credit unchanged.
  - More than one coin asserted: error=1, credit unchanged.
- DISPENSE:
  - busy=1. All coin, sel and cancel inputs are ignored: no credit change, no error.
  - The counter decrements each cycle. At 1 the next state is READY, with busy=0 in that cycle.
  - busy rises in the same cycle as the item pulse and stays high exactly DISPENSE_CYCLES cycles.
- error and an item pulse are never high together. At most one of apple/banana/carrot/date is high in any cycle.
- Credit is updated in the same cycle that the corresponding pulse appears, so the display manager sees post-vend credit once its item hold expires.

Test Plan:
- Reset, then quarter strobes in 3 separate cycles -> credit 8'h25, 8'h50, 8'h75, each one cycle after its strobe; no error.
- Credit 75, selA -> next cycle apple=1 for 1 cycle, credit=8'h00, busy=1 for 4 cycles. selB during busy gives no pulse and no error. busy=0 in the 5th cycle.
- Credit 40, selA -> error=1 for 1 cycle, credit stays 8'h40, busy stays 0. selA+selB in the same cycle with credit 95 -> error, credit 8'h95.
- Credit 90, dime -> error, credit 8'h90. Then nickel -> credit 8'h95. nickel+dime in the same cycle -> error, credit unchanged.
- Credit 60, cancel+quarter in the same cycle -> change_valid=1 for 1 cycle, change=8'h60, credit=8'h00, quarter dropped with no error.
- Credit 50, selB, then reset asserted during the 2nd DISPENSE cycle -> next cycle busy=0, credit=8'h00, all pulses 0. A quarter after that gives credit 8'h25.
